// File: rtl/chacha20_decrypt_rx.sv
// Receive-side ChaCha20 decryptor: parses a 16-byte nonce/counter header, then XORs the
// ciphertext with keystream from an iterative ChaCha20 block core (one half double-round/cycle).

module chacha20_block (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         done,
  output logic [511:0] keystream_block
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] a1, b1, c1, d1;
    a1 = a + b;   d1 = rotl(d ^ a1, 16);
    c1 = c + d1;  b1 = rotl(b ^ c1, 12);
    a1 = a1 + b1; d1 = rotl(d1 ^ a1, 8);
    c1 = c1 + d1; b1 = rotl(b1 ^ c1, 7);
    return {a1, b1, c1, d1};
  endfunction

  logic [31:0]  x_q    [16];
  logic [31:0]  init_q [16];
  logic [31:0]  init_w [16];
  logic [31:0]  rnd    [16];
  logic [4:0]   round_q;
  logic         busy_q;
  logic         done_q;
  logic [511:0] ks_q;
  logic         load;

  assign load            = start && !busy_q;
  assign done            = done_q;
  assign keystream_block = ks_q;

  always_comb begin
    init_w[0] = 32'h61707865;
    init_w[1] = 32'h3320646e;
    init_w[2] = 32'h79622d32;
    init_w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4+i] = key[32*i +: 32];
    init_w[12] = counter;
    for (int j = 0; j < 3; j++) init_w[13+j] = nonce[32*j +: 32];
  end

  // Even rounds work on columns, odd rounds on diagonals.
  always_comb begin
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) rnd[i] = x_q[i];
    if (!round_q[0]) begin
      for (int c = 0; c < 4; c++) begin
        t = qr(x_q[c], x_q[c+4], x_q[c+8], x_q[c+12]);
        rnd[c]    = t[127:96];
        rnd[c+4]  = t[95:64];
        rnd[c+8]  = t[63:32];
        rnd[c+12] = t[31:0];
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        t = qr(x_q[c], x_q[4+(c+1)%4], x_q[8+(c+2)%4], x_q[12+(c+3)%4]);
        rnd[c]            = t[127:96];
        rnd[4+(c+1)%4]    = t[95:64];
        rnd[8+(c+2)%4]    = t[63:32];
        rnd[12+(c+3)%4]   = t[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      round_q <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        busy_q  <= 1'b1;
        round_q <= 5'd0;
      end else if (busy_q) begin
        round_q <= round_q + 5'd1;
        if (round_q == 5'd19) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        x_q[i]    <= init_w[i];
        init_q[i] <= init_w[i];
      end
    end else if (busy_q) begin
      for (int i = 0; i < 16; i++) x_q[i] <= rnd[i];
      if (round_q == 5'd19) begin
        for (int i = 0; i < 16; i++) ks_q[32*i +: 32] <= rnd[i] + init_q[i];
      end
    end
  end

endmodule

module chacha20_decrypt_rx (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         done,
  output logic         header_error
);

  typedef enum logic [1:0] {StHdr, StKeygen, StData, StDrain} state_e;

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [5:0]   pos_q, pos_d;
  logic [95:0]  nonce_q, nonce_d;
  logic [31:0]  counter_q, counter_d;
  logic [511:0] ks_q, ks_d;
  logic         kg_first_q, kg_first_d;
  logic [7:0]   out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         done_q, done_d;
  logic         hdr_err_q, hdr_err_d;

  logic         ks_start;
  logic         core_done;
  logic [511:0] core_ks;
  logic         in_fire;
  logic         out_fire;
  logic [7:0]   ks_byte;

  assign ks_start     = kg_first_q;
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid_q && out_ready;
  assign ks_byte      = ks_q[{pos_q, 3'b000} +: 8];
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign header_error = hdr_err_q;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StHdr:   in_ready = 1'b1;
        StData:  in_ready = !out_valid_q || out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  chacha20_block u_core (
    .clk             (clk),
    .rst_n           (~rst),
    .start           (ks_start),
    .key             (key),
    .nonce           (nonce_q),
    .counter         (counter_q),
    .done            (core_done),
    .keystream_block (core_ks)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    nonce_d     = nonce_q;
    counter_d   = counter_q;
    ks_d        = ks_q;
    kg_first_d  = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    hdr_err_d   = 1'b0;

    if (out_fire) out_valid_d = 1'b0;

    unique case (state_q)
      StHdr: begin
        if (in_fire) begin
          for (int i = 0; i < 12; i++) begin
            if (idx_q == 4'(i)) nonce_d[8*i +: 8] = in_data;
          end
          for (int i = 0; i < 4; i++) begin
            if (idx_q == 4'(12 + i)) counter_d[8*i +: 8] = in_data;
          end
          if (in_last) begin
            // Header-only frame is a legal empty payload; shorter is malformed.
            idx_d = 4'd0;
            if (idx_q == 4'd15) done_d = 1'b1;
            else                hdr_err_d = 1'b1;
          end else if (idx_q == 4'd15) begin
            idx_d      = 4'd0;
            state_d    = StKeygen;
            kg_first_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StKeygen: begin
        if (core_done) begin
          ks_d    = core_ks;
          pos_d   = 6'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (in_fire) begin
          out_data_d  = in_data ^ ks_byte;
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          pos_d       = pos_q + 6'd1;
          if (in_last) begin
            state_d = StDrain;
          end else if (pos_q == 6'd63) begin
            state_d    = StKeygen;
            kg_first_d = 1'b1;
            counter_d  = counter_q + 32'd1;
            pos_d      = 6'd0;
          end
        end
      end
      StDrain: begin
        if (out_fire && out_last_q) begin
          state_d = StHdr;
          done_d  = 1'b1;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHdr;
      idx_q       <= 4'd0;
      pos_q       <= 6'd0;
      nonce_q     <= '0;
      counter_q   <= '0;
      ks_q        <= '0;
      kg_first_q  <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      nonce_q     <= nonce_d;
      counter_q   <= counter_d;
      ks_q        <= ks_d;
      kg_first_q  <= kg_first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

endmodule

// File: tb/tb_chacha20_decrypt_rx.sv
// Scoreboard bench for chacha20_decrypt_rx: RFC 8439 vector, block boundaries, backpressure,
// header errors, counter wrap and mid-frame reset.

module tb_chacha20_decrypt_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         done;
  logic         header_error;

  always #5 clk = ~clk;

  chacha20_decrypt_rx dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .done         (done),
    .header_error (header_error)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int herr_cnt = 0;
  int kg_cnt = 0;
  int out_cnt = 0;
  int ready_mode = 0;
  bit gap_en = 1'b0;

  logic [8:0] sb_q [$];
  logic [7:0] ct_q [$];
  logic [7:0] pt_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ChaCha20 block function, computed in one shot.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] ctr,
                                              input logic [95:0] n);
    logic [31:0] s [16];
    logic [31:0] w [16];
    logic [511:0] r;
    int q [8][4];
    q = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    w = s;
    for (int r2 = 0; r2 < 10; r2++) begin
      for (int j = 0; j < 8; j++) begin
        int a, b, c, d;
        a = q[j][0]; b = q[j][1]; c = q[j][2]; d = q[j][3];
        w[a] += w[b]; w[d] = rl(w[d] ^ w[a], 16);
        w[c] += w[d]; w[b] = rl(w[b] ^ w[c], 12);
        w[a] += w[b]; w[d] = rl(w[d] ^ w[a], 8);
        w[c] += w[d]; w[b] = rl(w[b] ^ w[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic       stall_prev = 1'b0;
  logic [8:0] stall_val;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      logic [63:0] exp64;
      if (stall_prev) check_eq("stall_stable", {out_valid, out_last, out_data}, {1'b1, stall_val});
      if (done) done_cnt++;
      if (header_error) herr_cnt++;
      if (done || header_error) check_eq("done_herr_excl", 64'(done & header_error), 64'd0);
      if (dut.ks_start) kg_cnt++;
      if (out_valid && out_ready) begin
        out_cnt++;
        exp64 = (sb_q.size() != 0) ? 64'(sb_q.pop_front()) : 64'hdead;
        check_eq("out_byte", 64'({out_last, out_data}), exp64);
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic last);
    int  waited;
    bit  acc;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    acc      = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      waited++;
    end while (!acc && waited < 3000);
    check_eq("in_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gen_model_frame(input logic [95:0] n, input logic [31:0] ctr, input int len);
    logic [511:0] blk;
    logic [7:0]   p;
    pt_q.delete();
    ct_q.delete();
    blk = '0;
    for (int i = 0; i < len; i++) begin
      if (i % 64 == 0) blk = chacha_ref(key, ctr + 32'(i / 64), n);
      p = 8'($urandom);
      pt_q.push_back(p);
      ct_q.push_back(p ^ blk[8*(i%64) +: 8]);
    end
  endtask

  task automatic send_header(input logic [95:0] n, input logic [31:0] ctr, input bit last15);
    for (int i = 0; i < 16; i++) begin
      if (i < 12) drive_byte(n[8*i +: 8], 1'b0);
      else        drive_byte(ctr[8*(i-12) +: 8], last15 && i == 15);
    end
  endtask

  task automatic run_frame(input string tag, input logic [95:0] n, input logic [31:0] ctr,
                           input int exp_kg);
    int d0, h0, k0, o0, w;
    d0 = done_cnt; h0 = herr_cnt; k0 = kg_cnt; o0 = out_cnt;
    send_header(n, ctr, ct_q.size() == 0);
    for (int i = 0; i < ct_q.size(); i++) begin
      logic last;
      last = (i == ct_q.size() - 1);
      sb_q.push_back({last, pt_q[i]});
      drive_byte(ct_q[i], last);
    end
    w = 0;
    while (sb_q.size() != 0 && w < 5000) begin
      tick();
      w++;
    end
    repeat (5) tick();
    check_eq({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
    check_eq({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_herr"}, 64'(herr_cnt - h0), 64'd0);
    check_eq({tag, "_keygens"}, 64'(kg_cnt - k0), 64'(exp_kg));
    check_eq({tag, "_outcount"}, 64'(out_cnt - o0), 64'(ct_q.size()));
  endtask

  task automatic load_rfc();
    logic [911:0] rfc_ct;
    string        s;
    rfc_ct = {128'h6e2e359a2568f98041ba0728dd0d6981, 128'he97e7aec1d4360c20a27afccfd9fae0b,
              128'hf91b65c5524733ab8f593dabcd62b357, 128'h1639d624e65152ab8f530c359f0861d8,
              128'h07ca0dbf500d6a6156a38e088a22b65e, 128'h52bc514d16ccf806818ce91ab7793736,
              128'h5af90bbf74a35be6b40b8eedf2785e42, 16'h874d};
    s = {"Ladies and Gentlemen of the class of '99: If I could offer you only one tip ",
         "for the future, sunscreen would be it."};
    pt_q.delete();
    ct_q.delete();
    for (int i = 0; i < 114; i++) begin
      ct_q.push_back(rfc_ct[911-8*i -: 8]);
      pt_q.push_back(8'(s[i]));
    end
  endtask

  initial begin
    logic [95:0] rfc_nonce;
    logic [95:0] nz;
    int d0, h0, o0, k0;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] rfc_nonce;
    logic [95:0] nz;
    int d0, h0, o0, k0;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    rfc_nonce = '0;
    rfc_nonce[63:56] = 8'h4a;
    nz = 96'h0b0a_0908_0706_0504_0302_0100;

    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_outputs", 64'({out_data, out_valid, out_last, done, header_error}), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);
    tick();

    load_rfc();
    run_frame("rfc", rfc_nonce, 32'd1, 2);

    gen_model_frame(nz, 32'd7, 64);
    run_frame("len64", nz, 32'd7, 1);
    gen_model_frame(nz, 32'd7, 65);
    run_frame("len65", nz, 32'd7, 2);

    ready_mode = 1; gap_en = 1'b1;
    load_rfc();
    run_frame("rfc_bp", rfc_nonce, 32'd1, 2);
    ready_mode = 0; gap_en = 1'b0;

    d0 = done_cnt; h0 = herr_cnt; o0 = out_cnt;
    for (int i = 0; i < 8; i++) drive_byte(8'(i), i == 7);
    repeat (5) tick();
    check_eq("hdr7_herr", 64'(herr_cnt - h0), 64'd1);
    check_eq("hdr7_done", 64'(done_cnt - d0), 64'd0);
    check_eq("hdr7_noout", 64'(out_cnt - o0), 64'd0);
    gen_model_frame(nz, 32'd3, 20);
    run_frame("after_herr", nz, 32'd3, 1);

    d0 = done_cnt; h0 = herr_cnt; o0 = out_cnt; k0 = kg_cnt;
    send_header(nz, 32'd5, 1'b1);
    repeat (5) tick();
    check_eq("hdr15_done", 64'(done_cnt - d0), 64'd1);
    check_eq("hdr15_herr", 64'(herr_cnt - h0), 64'd0);
    check_eq("hdr15_noout", 64'(out_cnt - o0), 64'd0);
    check_eq("hdr15_nokg", 64'(kg_cnt - k0), 64'd0);

    gen_model_frame(nz, 32'hffff_ffff, 70);
    run_frame("wrap", nz, 32'hffff_ffff, 2);

    ready_mode = 2;
    repeat (2) tick();
    gen_model_frame(nz, 32'd9, 10);
    send_header(nz, 32'd9, 1'b0);
    drive_byte(ct_q[0], 1'b0);
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", 64'({out_data, out_valid, out_last, done, header_error}), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    sb_q.delete();
    ready_mode = 0;
    tick();
    tick();
    gen_model_frame(nz, 32'd11, 90);
    run_frame("after_rst", nz, 32'd11, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
